// File: rtl/game_clk_div.sv
// Rate-selectable divider producing clk_game and its rising-edge strobe clk_game_tick.
// Outputs registered; rate is sampled at the first clk edge of each half-period.
module game_clk_div #(
  parameter longint unsigned HALF_0 = 25_000_000,
  parameter longint unsigned HALF_1 = 12_500_000,
  parameter longint unsigned HALF_2 = 6_250_000,
  parameter longint unsigned HALF_3 = 3_125_000,
  parameter int unsigned     CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] clk_rate,
  output logic       clk_game,
  output logic       clk_game_tick
);

  // Terminal counts; HALF_n <= 2^CNT_W so HALF_n-1 always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] TERM_0 = CNT_W'(HALF_0 - 64'd1);
  localparam logic [CNT_W-1:0] TERM_1 = CNT_W'(HALF_1 - 64'd1);
  localparam logic [CNT_W-1:0] TERM_2 = CNT_W'(HALF_2 - 64'd1);
  localparam logic [CNT_W-1:0] TERM_3 = CNT_W'(HALF_3 - 64'd1);
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic [1:0]       rate_q;
  logic [1:0]       sel;
  logic [CNT_W-1:0] term_cnt;
  logic             terminal;

  // A fresh half-period uses the live select so the new rate applies without delay.
  always_comb begin
    sel      = (cnt == '0) ? clk_rate : rate_q;
    term_cnt = TERM_0;
    case (sel)
      2'd0:    term_cnt = TERM_0;
      2'd1:    term_cnt = TERM_1;
      2'd2:    term_cnt = TERM_2;
      default: term_cnt = TERM_3;
    endcase
    terminal = (cnt == term_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      rate_q        <= 2'd0;
      clk_game      <= 1'b0;
      clk_game_tick <= 1'b0;
    end else begin
      if (cnt == '0) begin
        rate_q <= clk_rate;
      end
      if (terminal) begin
        cnt           <= '0;
        clk_game      <= ~clk_game;
        clk_game_tick <= ~clk_game;
      end else begin
        cnt           <= cnt + ONE;
        clk_game_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_clk_div.sv
// Bench for game_clk_div with HALF = 4/3/2/1: expected clk_game toggle edges are queued by
// the stimulus; a monitor checks every cycle's clk_game level and tick against that queue.
module tb_game_clk_div;

  typedef struct {
    int   e;
    logic v;
  } tog_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] clk_rate;
  logic       clk_game;
  logic       clk_game_tick;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n;
  tog_t exp_q[$];
  logic mon_en = 1'b1;

  game_clk_div #(
    .HALF_0(4),
    .HALF_1(3),
    .HALF_2(2),
    .HALF_3(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_rate     (clk_rate),
    .clk_game     (clk_game),
    .clk_game_tick(clk_game_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge 1 is the first rising edge with rst_n high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_n, act, req);
    end
  endtask

  task automatic push_tog(input int e, input logic v);
    tog_t t;
    t.e = e;
    t.v = v;
    exp_q.push_back(t);
  endtask

  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (edge_n != k && guard < 500);
    if (edge_n != k) chk("wait_edge", edge_n, k);
  endtask

  // Monitor: level and tick are predicted solely from the expected toggle queue.
  initial begin
    logic last_v;
    tog_t t;
    last_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_v = 1'b0;
      end else if (mon_en) begin
        if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
          t = exp_q.pop_front();
          chk("toggle_level", clk_game, t.v);
          chk("toggle_tick", clk_game_tick, t.v);
          last_v = t.v;
        end else begin
          chk("hold_level", clk_game, last_v);
          chk("hold_tick", clk_game_tick, 1'b0);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    clk_rate = 2'd2;

    // Reset held with a nonzero rate: outputs stay low.
    repeat (5) begin
      @(negedge clk);
      chk("rst_game", clk_game, 1'b0);
      chk("rst_tick", clk_game_tick, 1'b0);
    end

    // Rate 0: half-period 4.
    clk_rate = 2'd0;
    push_tog(4, 1'b1);
    push_tog(8, 1'b0);
    push_tog(12, 1'b1);
    push_tog(16, 1'b0);
    #1 rst_n = 1'b1;
    wait_edge(16);

    // Rate 3: toggles every edge.
    #1 clk_rate = 2'd3;
    for (int e = 17; e <= 24; e++) push_tog(e, logic'(e % 2));
    wait_edge(24);

    // Rate 0 half, then a change to rate 1 inside the following half.
    #1 clk_rate = 2'd0;
    push_tog(28, 1'b1);
    push_tog(32, 1'b0);
    push_tog(35, 1'b1);
    push_tog(38, 1'b0);
    push_tog(41, 1'b1);
    push_tog(44, 1'b0);
    wait_edge(30);
    #1 clk_rate = 2'd1;
    wait_edge(44);

    // Asynchronous reset one cycle into a high phase.
    #1 clk_rate = 2'd0;
    push_tog(48, 1'b1);
    wait_edge(49);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_game", clk_game, 1'b0);
    chk("async_rst_tick", clk_game_tick, 1'b0);
    chk("async_rst_queue", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);

    // Sweep 0,1,2,3 for three periods each: halves 4,3,2,1.
    for (int e = 4; e <= 24; e += 4) push_tog(e, logic'((e / 4) % 2));
    #1 rst_n = 1'b1;
    wait_edge(24);
    #1 clk_rate = 2'd1;
    for (int i = 1; i <= 6; i++) push_tog(24 + 3 * i, logic'(i % 2));
    wait_edge(42);
    #1 clk_rate = 2'd2;
    for (int i = 1; i <= 6; i++) push_tog(42 + 2 * i, logic'(i % 2));
    wait_edge(54);
    #1 clk_rate = 2'd3;
    for (int i = 1; i <= 6; i++) push_tog(54 + i, logic'(i % 2));
    wait_edge(60);
    mon_en = 1'b0;
    chk("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
